coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end stage directly upstream of the coffee vending FSM. Synchronises and debounces the raw 5c and 10c coin-sensor lines and rejects glitches, double-sensing and jammed coins. Emits a one-cycle coin code on the 2-bit bus the vending FSM samples every clock: 01 = 5c, 10 = 10c, 00 = none.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-high cycles needed to accept a coin; also the release-low filter length; range 2..255.
JAM_CYCLES, 64, cycles a sensor may stay high after acceptance before jam is declared; must exceed DEBOUNCE_CYCLES.
CNT_W, 8, width of the internal counter; must hold max(DEBOUNCE_CYCLES, JAM_CYCLES).

Ports:
clk  input  1  system clock, all logic on posedge.
rstn  input  1  reset; synchronous and active-high despite the name.
sense_5  input  1  raw 5c sensor, asynchronous to clk.
sense_10  input  1  raw 10c sensor, asynchronous to clk.
accept_en  input  1  downstream can take coins; low = reject all coins.
coin  output  2  registered one-cycle coin code to the vending FSM.
reject  output  1  one-cycle pulse: coin refused (double-sense or accept_en low).
jam  output  1  level: sensor stuck high; clears on release.

Behaviour:
- Reset (rstn=1 at posedge): state IDLE, counter 0, synchroniser flops 0, coin=00, reject=0, jam=0. Reset mid-operation aborts any qualification; no output is emitted.
- Each sensor passes through a 2-flop synchroniser giving s5 and s10. The FSM sees only s5 and s10.
- coin and reject are registered and never high for more than one cycle per coin event. coin and reject are never asserted together.
- IDLE:
  - exactly one of s5/s10 high -> QUAL, cnt=1, latch the type.
  - both high -> QUAL with the double flag set.
  - otherwise stay.
- QUAL:
  - latched sensor still high and the other low -> cnt++.
  - latched sensor drops before qualifying -> IDLE (glitch, no output).
  - other sensor rises -> double flag set.
  - Qualification: when cnt reaches DEBOUNCE_CYCLES, go to WAIT_REL and, on the same clock:
    - double flag set -> reject=1;
    - else accept_en low -> reject=1;
    - else coin=01 (5c) or 10 (10c).
  - accept_en is sampled only in the qualifying cycle.
- WAIT_REL:
  - cnt counts cycles with either sensor high.
  - both low for DEBOUNCE_CYCLES consecutive cycles -> IDLE, cnt=0. Any high restarts the low filter.
  - cnt reaches JAM_CYCLES -> JAM.
- JAM:
  - jam=1; no coin or reject outputs.
  - both low for DEBOUNCE_CYCLES consecutive cycles -> IDLE, jam=0 on that transition.
- Latency: raw sensor first sampled high at edge N and held -> coin high for exactly the cycle following edge N+DEBOUNCE_CYCLES+2 (edge N+6 at default).
- Counter saturates at its terminal value and never wraps.

Optional Feature:
COIN_TALLY_EN:
- Defined: adds input tally_clr (1 bit) and output total_cents (16 bits, reset 0).
  - Each accepted coin adds 5 or 10 on the cycle coin asserts.
  - Saturates at 16'hFFFF.
  - tally_clr zeroes the tally; clear wins over a simultaneous add.
- Undefined: neither port exists and no tally logic is built.

Decomposition:
- Shared package coin_pkg:
  - coin code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10;
  - state typedef IDLE/QUAL/WAIT_REL/JAM;
  - value constants 5 and 10.
- The vending FSM imports the same coin constants.
- One natural sub-module, coin_sync (2-flop synchroniser, reset to 0), instantiated once per sensor.

Test Plan:
- sense_5 high from edge 10, held 20 cycles, accept_en=1 -> coin=01 for exactly one cycle after edge 16; reject=0, jam=0; IDLE again 4 cycles after release.
- sense_10 high for only 2 synchronised cycles -> no coin, no reject, back to IDLE.
- sense_5 and sense_10 both high 10 cycles -> reject=1 for one cycle, coin stays 00.
- sense_10 held with accept_en=0 at the qualifying cycle -> reject=1, coin=00; after release, a retry with accept_en=1 -> coin=10.
- sense_5 held 100 cycles -> one coin=01 pulse, then jam=1 at 64 cycles after acceptance; release -> jam=0 after 4 low cycles, no second coin.
- rstn=1 during QUAL, then sensor kept high -> no output for the aborted coin; qualification restarts from zero after reset. With COIN_TALLY_EN: 5c, 10c, 10c accepted -> total_cents=25; tally_clr -> 0.

Source files
------------

// File: rtl/coin_pkg.sv
// ============================================================================
// Module : coin_pkg
// Brief  : Coin codes, acceptor state encoding and coin values, shared by
//          coin_acceptor and the downstream vending FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam logic [15:0] COIN_5_CENTS  = 16'd5;
    localparam logic [15:0] COIN_10_CENTS = 16'd10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        WAIT_REL = 2'd2,
        JAM      = 2'd3
    } coin_state_e;

    function automatic logic [15:0] coin_cents(input logic [1:0] code);
        case (code)
            COIN_5:  coin_cents = COIN_5_CENTS;
            COIN_10: coin_cents = COIN_10_CENTS;
            default: coin_cents = 16'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/coin_sync.sv
// ============================================================================
// Module : coin_sync
// Brief  : Two-flop synchroniser for one raw coin-sensor line, resets to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_sync (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ============================================================================
// Module : coin_acceptor
// Brief  : Debounces the 5c/10c coin sensors, rejects glitches, double-sensed
//          and jammed coins, and emits a one-cycle coin code.
//          Optional build macro COIN_TALLY_EN adds a saturating cents tally.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64,
    parameter int CNT_W           = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sense_5,
    input  logic        sense_10,
    input  logic        accept_en,
    output logic [1:0]  coin,
    output logic        reject,
    output logic        jam
`ifdef COIN_TALLY_EN
    ,
    input  logic        tally_clr,
    output logic [15:0] total_cents
`endif
);

    localparam logic [CNT_W-1:0] c_DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_JAM_CNT = CNT_W'(JAM_CYCLES);

    logic w_s5;
    logic w_s10;

    coin_sync u_sync_5 (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (sense_5),
        .o_sync  (w_s5)
    );

    coin_sync u_sync_10 (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (sense_10),
        .o_sync  (w_s10)
    );

    coin_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_low, w_low_nxt;
    logic             r_is10, w_is10_nxt;
    logic             r_dbl, w_dbl_nxt;
    logic [1:0]       r_coin, w_coin_nxt;
    logic             r_rej, w_rej_nxt;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_low_inc;
    logic             w_lat;
    logic             w_oth;
    logic             w_any;

    // Both counters hold at all-ones rather than wrapping
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_low_inc = (r_low == {CNT_W{1'b1}}) ? r_low : r_low + 1'b1;
    assign w_lat     = r_is10 ? w_s10 : w_s5;
    assign w_oth     = r_is10 ? w_s5 : w_s10;
    assign w_any     = w_s5 | w_s10;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_low   <= '0;
            r_is10  <= 1'b0;
            r_dbl   <= 1'b0;
            r_coin  <= COIN_NONE;
            r_rej   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_low   <= w_low_nxt;
            r_is10  <= w_is10_nxt;
            r_dbl   <= w_dbl_nxt;
            r_coin  <= w_coin_nxt;
            r_rej   <= w_rej_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_low_nxt   = r_low;
        w_is10_nxt  = r_is10;
        w_dbl_nxt   = r_dbl;
        w_coin_nxt  = COIN_NONE;
        w_rej_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_low_nxt = '0;
                w_dbl_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt = QUAL;
                    w_cnt_nxt   = CNT_W'(1);
                    w_is10_nxt  = w_s10 & ~w_s5;
                    w_dbl_nxt   = w_s5 & w_s10;
                end
            end
            QUAL: begin
                // cnt already holds DEBOUNCE_CYCLES high samples: decide now
                if (r_cnt >= c_DEB_CNT) begin
                    w_state_nxt = WAIT_REL;
                    w_cnt_nxt   = '0;
                    w_low_nxt   = '0;
                    if (r_dbl || !accept_en) begin
                        w_rej_nxt = 1'b1;
                    end else begin
                        w_coin_nxt = r_is10 ? COIN_10 : COIN_5;
                    end
                end else if (w_lat) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_oth) begin
                        w_dbl_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_REL: begin
                if (w_any) begin
                    w_low_nxt = '0;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_JAM_CNT) begin
                        w_state_nxt = JAM;
                    end
                end else if (w_low_inc >= c_DEB_CNT) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_low_nxt   = '0;
                end else begin
                    w_low_nxt = w_low_inc;
                end
            end
            JAM: begin
                if (w_any) begin
                    w_low_nxt = '0;
                end else if (w_low_inc >= c_DEB_CNT) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_low_nxt   = '0;
                end else begin
                    w_low_nxt = w_low_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_low_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        coin   = r_coin;
        reject = r_rej;
        jam    = (r_state == JAM);
    end

`ifdef COIN_TALLY_EN
    logic [15:0] r_total;
    logic [16:0] w_sum;

    // Added alongside the coin register so the tally moves with the coin pulse
    assign w_sum = {1'b0, r_total} + {1'b0, coin_cents(w_coin_nxt)};

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_total <= 16'd0;
        end else if (tally_clr) begin
            r_total <= 16'd0;
        end else if (w_sum[16]) begin
            r_total <= 16'hFFFF;
        end else begin
            r_total <= w_sum[15:0];
        end
    end

    assign total_cents = r_total;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ============================================================================
// Module : tb_coin_acceptor
// Brief  : Directed self-checking bench for coin_acceptor (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coin_acceptor;
    import coin_pkg::*;

    logic        clk;
    logic        rstn;
    logic        sense_5;
    logic        sense_10;
    logic        accept_en;
    logic [1:0]  coin;
    logic        reject;
    logic        jam;
`ifdef COIN_TALLY_EN
    logic        tally_clr;
    logic [15:0] total_cents;
`endif

    int checks;
    int errors;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (4),
        .JAM_CYCLES      (64),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sense_5     (sense_5),
        .sense_10    (sense_10),
        .accept_en   (accept_en),
        .coin        (coin),
        .reject      (reject),
        .jam         (jam)
`ifdef COIN_TALLY_EN
        ,
        .tally_clr   (tally_clr),
        .total_cents (total_cents)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle before driving or sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge k of each loop is the k-th edge sampling the new raw sensor value
    task automatic test_reset();
        rstn = 1'b1;
        sense_5 = 1'b0;
        sense_10 = 1'b0;
        accept_en = 1'b1;
        repeat (3) tick();
        checks++;
        if (coin !== COIN_NONE) begin
            errors++;
            $display("FAIL reset_coin got %b want %b", coin, COIN_NONE);
        end
        checks++;
        if (reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_reject got %b want 0", reject);
        end
        checks++;
        if (jam !== 1'b0) begin
            errors++;
            $display("FAIL reset_jam got %b want 0", jam);
        end
        rstn = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_coin5();
        logic [1:0] exp_coin;
        accept_en = 1'b1;
        sense_5 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_coin = (k == 6) ? COIN_5 : COIN_NONE;
            checks++;
            if (coin !== exp_coin || reject !== 1'b0 || jam !== 1'b0) begin
                errors++;
                $display("FAIL coin5 edge %0d got coin=%b rej=%b jam=%b want coin=%b rej=0 jam=0",
                         k, coin, reject, jam, exp_coin);
            end
        end
        sense_5 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (coin !== COIN_NONE || reject !== 1'b0) begin
                errors++;
                $display("FAIL coin5_release edge %0d got coin=%b rej=%b want 00/0", k, coin, reject);
            end
        end
    endtask

    task automatic test_glitch();
        sense_10 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 2) sense_10 = 1'b0;
            tick();
            checks++;
            if (coin !== COIN_NONE || reject !== 1'b0) begin
                errors++;
                $display("FAIL glitch edge %0d got coin=%b rej=%b want 00/0", k, coin, reject);
            end
        end
    endtask

    task automatic test_double();
        logic exp_rej;
        sense_5 = 1'b1;
        sense_10 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                sense_5 = 1'b0;
                sense_10 = 1'b0;
            end
            tick();
            exp_rej = (k == 6);
            checks++;
            if (coin !== COIN_NONE || reject !== exp_rej) begin
                errors++;
                $display("FAIL double edge %0d got coin=%b rej=%b want coin=00 rej=%b",
                         k, coin, reject, exp_rej);
            end
        end
    endtask

    task automatic test_accept_en();
        logic [1:0] exp_coin;
        logic       exp_rej;
        for (int pass = 0; pass < 2; pass++) begin
            accept_en = (pass == 1);
            sense_10 = 1'b1;
            for (int k = 0; k < 20; k++) begin
                if (k == 10) sense_10 = 1'b0;
                tick();
                exp_rej  = (pass == 0) && (k == 6);
                exp_coin = ((pass == 1) && (k == 6)) ? COIN_10 : COIN_NONE;
                checks++;
                if (coin !== exp_coin || reject !== exp_rej) begin
                    errors++;
                    $display("FAIL accept_en%0d edge %0d got coin=%b rej=%b want coin=%b rej=%b",
                             pass, k, coin, reject, exp_coin, exp_rej);
                end
            end
        end
        accept_en = 1'b1;
    endtask

    task automatic test_jam();
        logic [1:0] exp_coin;
        logic       exp_jam;
        sense_5 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            exp_coin = (k == 6) ? COIN_5 : COIN_NONE;
            exp_jam  = (k >= 70);
            checks++;
            if (coin !== exp_coin || reject !== 1'b0 || jam !== exp_jam) begin
                errors++;
                $display("FAIL jam_hold edge %0d got coin=%b rej=%b jam=%b want coin=%b rej=0 jam=%b",
                         k, coin, reject, jam, exp_coin, exp_jam);
            end
        end
        sense_5 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_jam = (k < 5);
            checks++;
            if (coin !== COIN_NONE || reject !== 1'b0 || jam !== exp_jam) begin
                errors++;
                $display("FAIL jam_release edge %0d got coin=%b rej=%b jam=%b want coin=00 rej=0 jam=%b",
                         k, coin, reject, jam, exp_jam);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_coin;
        sense_5 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rstn = (k == 4);
            tick();
            exp_coin = (k == 11) ? COIN_5 : COIN_NONE;
            checks++;
            if (coin !== exp_coin || reject !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid edge %0d got coin=%b rej=%b want coin=%b rej=0",
                         k, coin, reject, exp_coin);
            end
        end
        rstn = 1'b0;
        sense_5 = 1'b0;
        repeat (10) tick();
    endtask

`ifdef COIN_TALLY_EN
    task automatic test_tally();
        logic [1:0] seq [3];
        seq[0] = COIN_5;
        seq[1] = COIN_10;
        seq[2] = COIN_10;
        tally_clr = 1'b1;
        tick();
        tally_clr = 1'b0;
        checks++;
        if (total_cents !== 16'd0) begin
            errors++;
            $display("FAIL tally_start got %0d want 0", total_cents);
        end
        for (int c = 0; c < 3; c++) begin
            sense_5  = (seq[c] == COIN_5);
            sense_10 = (seq[c] == COIN_10);
            repeat (10) tick();
            sense_5  = 1'b0;
            sense_10 = 1'b0;
            repeat (10) tick();
        end
        checks++;
        if (total_cents !== 16'd25) begin
            errors++;
            $display("FAIL tally_sum got %0d want 25", total_cents);
        end
        tally_clr = 1'b1;
        tick();
        tally_clr = 1'b0;
        checks++;
        if (total_cents !== 16'd0) begin
            errors++;
            $display("FAIL tally_clr got %0d want 0", total_cents);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b1;
        sense_5 = 1'b0;
        sense_10 = 1'b0;
        accept_en = 1'b1;
`ifdef COIN_TALLY_EN
        tally_clr = 1'b0;
`endif
        test_reset();
        test_coin5();
        test_glitch();
        test_double();
        test_accept_en();
        test_jam();
        test_reset_mid();
`ifdef COIN_TALLY_EN
        test_tally();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
